// File: rtl/pi_bus_master.sv
// pi_bus_master: host-side burst master for the PI multiplexed address/data bus.
module pi_bus_master #(
  parameter int ALE_CYC    = 4,
  parameter int STROBE_CYC = 8,
  parameter int GAP_CYC    = 4
) (
  input  logic        clk,
  input  logic        cold_reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [7:0]  cmd_len,
  input  logic [15:0] wr_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  output logic [15:0] rd_data,
  output logic        rd_valid,
  output logic        busy,
  output logic        done,
  inout  wire  [15:0] ad,
  output logic        aleh,
  output logic        alel,
  output logic        read,
  output logic        write
);
  typedef enum logic [2:0] {IDLE, ADDR_HI, ADDR_LO, ALE_GAP, WAIT_WR, STROBE, RECOVER} state_t;
  localparam logic [7:0] ALE_N = 8'(ALE_CYC - 1);
  localparam logic [7:0] STB_N = 8'(STROBE_CYC - 1);
  localparam logic [7:0] GAP_N = 8'(GAP_CYC - 1);
  state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [8:0] words_q, words_d;
  logic [31:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d, rd_data_q, rd_data_d, ad_out_q, ad_out_d;
  logic dir_q, dir_d, rd_valid_q, rd_valid_d, done_q, done_d;
  logic aleh_q, aleh_d, alel_q, alel_d, read_q, read_d, write_q, write_d, ad_oe_q, ad_oe_d;
  logic last;
  assign last = cnt_q == 8'd0;
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q - 8'd1;
    words_d    = words_q;
    addr_d     = addr_q;
    dir_d      = dir_q;
    wdata_d    = wdata_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = 8'd0;
        if (cmd_valid) begin
          state_d = ADDR_HI;
          cnt_d   = ALE_N;
          addr_d  = cmd_addr & 32'hFFFF_FFFE;
          words_d = {1'b0, cmd_len} + 9'd1;
          dir_d   = cmd_write;
        end
      end
      ADDR_HI: if (last) begin
        state_d = ADDR_LO;
        cnt_d   = ALE_N;
      end
      ADDR_LO: if (last) begin
        state_d = ALE_GAP;
        cnt_d   = GAP_N;
      end
      ALE_GAP: if (last) begin
        state_d = dir_q ? WAIT_WR : STROBE;
        cnt_d   = dir_q ? 8'd0 : STB_N;
      end
      WAIT_WR: begin
        cnt_d = 8'd0;
        if (wr_valid) begin
          state_d = STROBE;
          cnt_d   = STB_N;
          wdata_d = wr_data;
        end
      end
      STROBE: if (last) begin
        state_d    = RECOVER;
        cnt_d      = GAP_N;
        rd_data_d  = dir_q ? rd_data_q : ad;
        rd_valid_d = !dir_q;
      end
      RECOVER: if (last) begin
        words_d = words_q - 9'd1;
        done_d  = words_q == 9'd1;
        state_d = done_d ? IDLE : dir_q ? WAIT_WR : STROBE;
        cnt_d   = (done_d || dir_q) ? 8'd0 : STB_N;
      end
      default: state_d = IDLE;
    endcase
    aleh_d   = state_d == ADDR_HI;
    alel_d   = state_d == ADDR_HI || state_d == ADDR_LO;
    read_d   = !(state_d == STROBE && !dir_d);
    write_d  = !(state_d == STROBE && dir_d);
    // write data stays on the bus for one clock of hold after the strobe rises
    ad_oe_d  = alel_d || (dir_d && (state_d == STROBE || (state_d == RECOVER && state_q == STROBE)));
    ad_out_d = aleh_d ? addr_d[31:16] : alel_d ? addr_d[15:0] : wdata_d;
  end
  always_ff @(posedge clk) begin
    if (cold_reset) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      words_q    <= 9'd0;
      addr_q     <= 32'd0;
      dir_q      <= 1'b0;
      wdata_q    <= 16'd0;
      rd_data_q  <= 16'd0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      aleh_q     <= 1'b0;
      alel_q     <= 1'b0;
      read_q     <= 1'b1;
      write_q    <= 1'b1;
      ad_oe_q    <= 1'b0;
      ad_out_q   <= 16'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      words_q    <= words_d;
      addr_q     <= addr_d;
      dir_q      <= dir_d;
      wdata_q    <= wdata_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      done_q     <= done_d;
      aleh_q     <= aleh_d;
      alel_q     <= alel_d;
      read_q     <= read_d;
      write_q    <= write_d;
      ad_oe_q    <= ad_oe_d;
      ad_out_q   <= ad_out_d;
    end
  end
  assign ad        = ad_oe_q ? ad_out_q : 16'hzzzz;
  assign cmd_ready = state_q == IDLE;
  assign busy      = state_q != IDLE;
  assign wr_ready  = state_q == WAIT_WR && wr_valid;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign done      = done_q;
  assign aleh      = aleh_q;
  assign alel      = alel_q;
  assign read      = read_q;
  assign write     = write_q;
endmodule
